// File: rtl/write_back_stage.sv
// RV32 write-back stage: one slot that captures a decoded instruction, formats load data and drives the register-file write port.
// Non-loads write one cycle after capture (1/cycle back-to-back); loads hold in_ready low until mem_rdata_valid arrives.

package write_back_pkg;

   typedef struct packed {
      logic       write_enable;
      logic [4:0] addr_rd;
   } reg_file_write_params_t;

   typedef logic [1:0] write_back_select_t;

   localparam write_back_select_t WB_SEL_ALU = 2'd0;
   localparam write_back_select_t WB_SEL_MEM = 2'd1;
   localparam write_back_select_t WB_SEL_PC  = 2'd2;

endpackage

module write_back_stage
   import write_back_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int RETIRE_CNT_W = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   input  reg_file_write_params_t  wb_params,
   input  write_back_select_t      wb_sel,
   input  logic [XLEN-1:0]         alu_result,
   input  logic [XLEN-1:0]         pc,
   input  logic [2:0]              load_funct3,
   input  logic [XLEN-1:0]         mem_rdata,
   input  logic                    mem_rdata_valid,
   output logic                    rf_we,
   output logic [REG_ADDR_W-1:0]   rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic                    load_fault,
   output logic [RETIRE_CNT_W-1:0] retired_count
);

   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_WAIT_MEM = 2'd1;
   localparam logic [1:0] ST_READY    = 2'd2;

   logic [1:0]             state;
   logic [1:0]             state_nxt;

   reg_file_write_params_t s_params;
   write_back_select_t     s_sel;
   logic [XLEN-1:0]        s_alu;
   logic [1:0]             s_off;
   logic [XLEN-1:0]        s_pc4;
   logic [2:0]             s_funct3;
   logic [XLEN-1:0]        s_load_data;
   logic                   s_fault;

   logic                   capture;
   logic                   mem_take;
   logic                   ready_act;
   logic                   retire;
   logic [7:0]             byte_v;
   logic [15:0]            half_v;
   logic [XLEN-1:0]        fmt_data;
   logic                   fmt_fault;
   logic [XLEN-1:0]        result;

   assign in_ready  = (state != ST_WAIT_MEM);
   assign capture   = in_valid & in_ready & ~flush;
   assign mem_take  = (state == ST_WAIT_MEM) & mem_rdata_valid & ~flush;
   // Flush kills the held instruction combinationally, even while it sits in READY.
   assign ready_act = (state == ST_READY) & ~flush;
   assign retire    = ready_act & ~s_fault;

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else if (capture) begin
         state_nxt = (wb_sel == WB_SEL_MEM) ? ST_WAIT_MEM : ST_READY;
      end else begin
         case (state)
            ST_READY:    state_nxt = ST_EMPTY;
            ST_WAIT_MEM: state_nxt = mem_rdata_valid ? ST_READY : ST_WAIT_MEM;
            default:     state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      byte_v    = mem_rdata[{s_off, 3'b000} +: 8];
      half_v    = mem_rdata[{s_off[1], 4'b0000} +: 16];
      fmt_data  = '0;
      fmt_fault = 1'b0;
      case (s_funct3)
         3'b000: fmt_data = {{(XLEN-8){byte_v[7]}}, byte_v};
         3'b100: fmt_data = {{(XLEN-8){1'b0}}, byte_v};
         3'b001: begin
            fmt_data  = {{(XLEN-16){half_v[15]}}, half_v};
            fmt_fault = s_off[0];
         end
         3'b101: begin
            fmt_data  = {{(XLEN-16){1'b0}}, half_v};
            fmt_fault = s_off[0];
         end
         3'b010: begin
            fmt_data  = mem_rdata;
            fmt_fault = (s_off != 2'b00);
         end
         default: fmt_fault = 1'b1;
      endcase
   end

   always_comb begin
      case (s_sel)
         WB_SEL_MEM: result = s_load_data;
         WB_SEL_PC:  result = s_pc4;
         default:    result = s_alu;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_EMPTY;
         s_params      <= '0;
         s_sel         <= '0;
         s_alu         <= '0;
         s_off         <= '0;
         s_pc4         <= '0;
         s_funct3      <= '0;
         s_load_data   <= '0;
         s_fault       <= 1'b0;
         retired_count <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            s_params <= wb_params;
            s_sel    <= wb_sel;
            s_alu    <= alu_result;
            s_off    <= alu_result[1:0];
            s_pc4    <= pc + XLEN'(4);
            s_funct3 <= load_funct3;
            // A fresh instruction must not inherit the previous load's fault.
            s_fault  <= 1'b0;
         end else if (mem_take) begin
            s_load_data <= fmt_data;
            s_fault     <= fmt_fault;
         end
         if (retire) begin
            retired_count <= retired_count + RETIRE_CNT_W'(1);
         end
      end
   end

   assign rf_we      = ready_act & s_params.write_enable & (s_params.addr_rd != 5'd0) & ~s_fault;
   assign rf_waddr   = REG_ADDR_W'(s_params.addr_rd);
   assign rf_wdata   = result;
   assign load_fault = ready_act & s_fault;

endmodule
